// File: rtl/router_port_arbiter.sv
// Round-robin packet arbiter for one shared router output port with registered-owner steering.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD beats of a single grant.
module router_port_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        last,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        gnt,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    timeout
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {StIdle, StOwn} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              beat;
    logic              force_rel;
    logic              any_req;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     cand;
    logic [DATA_W-1:0] data_arr [N_REQ];

    always_comb begin
        for (int k = 0; k < int'(N_REQ); k++) begin
            data_arr[k] = in_data[k*DATA_W +: DATA_W];
        end
    end

    // First set request at or after rr_ptr, wrapping around.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = PW'((32'(rr_ptr_q) + i) % N_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    assign busy      = (state_q == StOwn);
    assign gnt       = gnt_q;
    assign out_valid = busy & req[owner_q];
    assign out_data  = busy ? data_arr[owner_q] : '0;
    assign out_last  = busy & last[owner_q];
    assign beat      = out_valid & out_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q;

    assign force_rel = beat & ~out_last & (hold_q == HW'(MAX_HOLD - 1));
    assign timeout   = timeout_q;

    // Held at zero while idle so every grant starts counting from zero; saturates.
    always_comb begin
        hold_d = hold_q;
        if (state_q == StIdle) begin
            hold_d = '0;
        end else if (beat && (hold_q != {HW{1'b1}})) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StOwn;
                    owner_d = winner;
                    gnt_d   = N_REQ'(1) << winner;
                end
            end
            StOwn: begin
                if ((beat & out_last) | ~req[owner_q] | force_rel) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
        end
    end

endmodule
